// File: rtl/branch_target_predictor.sv
// Purpose     : direct-mapped BTB with 2-bit counters; fetch-side lookup, buffered resolve-side training.
// Latency     : lookup 1 cycle (registered); a queued update reaches the table one cycle per entry in RUN.
// Backpressure: upd_ready_o drops when fewer than two FIFO slots are free; an unaccepted pair is dropped (upd_drop_o).
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   lu_valid_i, lu_pc_i          fetch lookup request
//   pred_valid_o/taken_o/target_o  registered prediction for last cycle's lookup
//   upd_valid_i[1:0]             per-slot outcome valid (bit0 = ir0 older, bit1 = ir1 younger)
//   upd_pc0_i/upd_pc1_i          branch/jal PCs
//   upd_target0_i/upd_target1_i  resolved targets
//   upd_taken_i/upd_is_jal_i     per-slot resolved direction and JAL flag
//   upd_ready_o                  FIFO can take a full pair this cycle
//   upd_drop_o                   previous cycle's pair was discarded
//   init_busy_o                  table-clear sweep in progress

module branch_target_predictor #(
  parameter int Entries  = 16,
  parameter int TagW     = 8,
  parameter int UpdDepth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lu_valid_i,
  input  logic [31:0] lu_pc_i,
  output logic        pred_valid_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic [1:0]  upd_valid_i,
  input  logic [31:0] upd_pc0_i,
  input  logic [31:0] upd_pc1_i,
  input  logic [31:0] upd_target0_i,
  input  logic [31:0] upd_target1_i,
  input  logic [1:0]  upd_taken_i,
  input  logic [1:0]  upd_is_jal_i,
  output logic        upd_ready_o,
  output logic        upd_drop_o,
  output logic        init_busy_o
);

  localparam int IdxW = $clog2(Entries);
  localparam int PtrW = $clog2(UpdDepth);
  localparam int CntW = PtrW + 1;

  typedef struct packed {
    logic [TagW-1:0] tag;
    logic [IdxW-1:0] idx;
    logic [30:0]     target;
    logic            taken;
    logic            is_jal;
  } upd_t;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // ---------------------------------------------------------------- FSM
  state_t          r_state;
  state_t          w_state_nxt;
  logic [IdxW-1:0] r_sweep_idx;
  logic [IdxW-1:0] w_sweep_idx_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_INIT;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    case (r_state)
      ST_INIT: begin
        w_sweep_idx_nxt = r_sweep_idx + IdxW'(1);
        if (r_sweep_idx == IdxW'(Entries - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // -------------------------------------------------------------- table
  // Only valid bits need clearing; tag/target/ctr are don't-care while invalid.
  logic [Entries-1:0] r_tbl_valid;
  logic [TagW-1:0]    r_tbl_tag    [Entries];
  logic [30:0]        r_tbl_target [Entries];
  logic [1:0]         r_tbl_ctr    [Entries];

  // ------------------------------------------------------------- lookup
  logic [IdxW-1:0] w_lu_idx;
  logic [TagW-1:0] w_lu_tag;
  logic            w_lu_hit;
  logic            r_pred_valid;
  logic            r_pred_taken;
  logic [31:0]     r_pred_target;

  assign w_lu_idx = lu_pc_i[IdxW:1];
  assign w_lu_tag = lu_pc_i[IdxW+TagW:IdxW+1];
  // Gating with RUN keeps the not-yet-swept (unknown) valid bits out of the result.
  assign w_lu_hit = lu_valid_i & (r_state == ST_RUN) & r_tbl_valid[w_lu_idx]
                  & (r_tbl_tag[w_lu_idx] == w_lu_tag);

  // Reads the table contents from before this edge's write (read-old).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_pred_valid  <= lu_valid_i;
      r_pred_taken  <= w_lu_hit & r_tbl_ctr[w_lu_idx][1];
      r_pred_target <= w_lu_hit ? {r_tbl_target[w_lu_idx], 1'b0} : '0;
    end
  end

  assign pred_valid_o  = r_pred_valid;
  assign pred_taken_o  = r_pred_taken;
  assign pred_target_o = r_pred_target;

  // --------------------------------------------------------- update FIFO
  upd_t            r_fifo [UpdDepth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_drop;
  logic            w_upd_ready;
  logic            w_upd_any;
  logic            w_push_en;
  logic [1:0]      w_push_n;
  logic            w_pop;
  upd_t            w_upd0;
  upd_t            w_upd1;
  upd_t            w_first;

  assign w_upd_ready = (r_count <= CntW'(UpdDepth - 2));
  assign w_upd_any   = |upd_valid_i;
  assign w_push_en   = w_upd_any & w_upd_ready;
  assign w_push_n    = {1'b0, upd_valid_i[0]} + {1'b0, upd_valid_i[1]};
  assign w_pop       = (r_state == ST_RUN) & (r_count != '0);

  assign w_upd0 = '{tag:    upd_pc0_i[IdxW+TagW:IdxW+1],
                    idx:    upd_pc0_i[IdxW:1],
                    target: upd_target0_i[31:1],
                    taken:  upd_taken_i[0],
                    is_jal: upd_is_jal_i[0]};
  assign w_upd1 = '{tag:    upd_pc1_i[IdxW+TagW:IdxW+1],
                    idx:    upd_pc1_i[IdxW:1],
                    target: upd_target1_i[31:1],
                    taken:  upd_taken_i[1],
                    is_jal: upd_is_jal_i[1]};
  // A lone ir1 takes the first free slot so the queue stays dense.
  assign w_first = upd_valid_i[0] ? w_upd0 : w_upd1;

  always_ff @(posedge clk_i) begin
    if (w_push_en & ~rst_i) begin
      r_fifo[r_wr_ptr] <= w_first;
      if (&upd_valid_i) begin
        r_fifo[r_wr_ptr + PtrW'(1)] <= w_upd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push_en) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(w_push_n);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + (w_push_en ? CntW'(w_push_n) : '0) - CntW'(w_pop);
      r_drop  <= w_upd_any & ~w_upd_ready;
    end
  end

  assign upd_ready_o = w_upd_ready;
  assign upd_drop_o  = r_drop;
  assign init_busy_o = (r_state == ST_INIT);

  // --------------------------------------------------------- table write
  upd_t       w_head;
  logic       w_head_hit;
  logic [1:0] w_head_ctr;
  logic [1:0] w_ctr_nxt;

  assign w_head     = r_fifo[r_rd_ptr];
  assign w_head_ctr = r_tbl_ctr[w_head.idx];
  assign w_head_hit = r_tbl_valid[w_head.idx] & (r_tbl_tag[w_head.idx] == w_head.tag);

  always_comb begin
    w_ctr_nxt = w_head_ctr;
    if (w_head.taken) begin
      if (w_head.is_jal) begin
        w_ctr_nxt = 2'd3;
      end else if (w_head_hit) begin
        w_ctr_nxt = (w_head_ctr == 2'd3) ? 2'd3 : w_head_ctr + 2'd1;
      end else begin
        w_ctr_nxt = 2'd2;
      end
    end else if (w_head_ctr != 2'd0) begin
      w_ctr_nxt = w_head_ctr - 2'd1;
    end
  end

  // Sweep and drain never overlap: drain only runs in RUN.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == ST_INIT) begin
        r_tbl_valid[r_sweep_idx] <= 1'b0;
      end else if (w_pop) begin
        if (w_head.taken) begin
          r_tbl_valid[w_head.idx]  <= 1'b1;
          r_tbl_tag[w_head.idx]    <= w_head.tag;
          r_tbl_target[w_head.idx] <= w_head.target;
          r_tbl_ctr[w_head.idx]    <= w_ctr_nxt;
        end else if (w_head_hit) begin
          r_tbl_ctr[w_head.idx]    <= w_ctr_nxt;
        end
      end
    end
  end

  // PC bits outside idx/tag and target bit 0 carry no information here.
  logic w_unused;
  assign w_unused = ^{lu_pc_i[31:IdxW+TagW+1], lu_pc_i[0],
                      upd_pc0_i[31:IdxW+TagW+1], upd_pc0_i[0],
                      upd_pc1_i[31:IdxW+TagW+1], upd_pc1_i[0],
                      upd_target0_i[0], upd_target1_i[0]};

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lu_valid_i = 1'b0;
  logic [31:0] lu_pc_i = '0;
  logic        pred_valid_o, pred_taken_o;
  logic [31:0] pred_target_o;
  logic [1:0]  upd_valid_i = '0;
  logic [31:0] upd_pc0_i = '0, upd_pc1_i = '0;
  logic [31:0] upd_target0_i = '0, upd_target1_i = '0;
  logic [1:0]  upd_taken_i = '0, upd_is_jal_i = '0;
  logic        upd_ready_o, upd_drop_o, init_busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  branch_target_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lu_valid_i(lu_valid_i), .lu_pc_i(lu_pc_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc0_i(upd_pc0_i), .upd_pc1_i(upd_pc1_i),
    .upd_target0_i(upd_target0_i), .upd_target1_i(upd_target1_i),
    .upd_taken_i(upd_taken_i), .upd_is_jal_i(upd_is_jal_i),
    .upd_ready_o(upd_ready_o), .upd_drop_o(upd_drop_o), .init_busy_o(init_busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: table arrays + update queue
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          taken;
    bit          jal;
  } upd_s;

  upd_s        q[$];
  bit          m_valid [16];
  int          m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_init = 1'b1;
  int          m_sweep = 0;
  logic        e_pv, e_pt, e_drop, e_busy, e_rdy;
  logic [31:0] e_ptgt;

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 1) % 16);
  endfunction

  function automatic int pc_tag(input logic [31:0] pc);
    return int'((pc >> 5) % 256);
  endfunction

  function automatic void apply_upd(input upd_s u);
    int i = pc_idx(u.pc);
    bit hit = m_valid[i] && (m_tag[i] == pc_tag(u.pc));
    if (u.taken) begin
      if (u.jal)     m_ctr[i] = 3;
      else if (hit)  m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      else           m_ctr[i] = 2;
      m_valid[i] = 1'b1;
      m_tag[i]   = pc_tag(u.pc);
      m_tgt[i]   = u.tgt & 32'hFFFF_FFFE;
    end else if (hit) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end
  endfunction

  task automatic model_step();
    if (rst_i) begin
      q.delete();
      m_init = 1'b1; m_sweep = 0;
      e_pv = 0; e_pt = 0; e_ptgt = '0; e_drop = 0;
    end else begin
      int  li  = pc_idx(lu_pc_i);
      bit  hit = lu_valid_i && !m_init && m_valid[li] && (m_tag[li] == pc_tag(lu_pc_i));
      bit  rdy = (q.size() <= 2);
      e_pv   = lu_valid_i;
      e_pt   = hit && (m_ctr[li] >= 2);
      e_ptgt = hit ? m_tgt[li] : 32'h0;
      e_drop = (upd_valid_i != 0) && !rdy;
      if (!m_init && q.size() > 0) apply_upd(q.pop_front());
      if (upd_valid_i != 0 && rdy) begin
        if (upd_valid_i[0]) q.push_back('{upd_pc0_i, upd_target0_i, upd_taken_i[0], upd_is_jal_i[0]});
        if (upd_valid_i[1]) q.push_back('{upd_pc1_i, upd_target1_i, upd_taken_i[1], upd_is_jal_i[1]});
      end
      if (m_init) begin
        m_valid[m_sweep] = 1'b0;
        if (m_sweep == 15) m_init = 1'b0;
        m_sweep = (m_sweep + 1) % 16;
      end
    end
    e_busy = m_init;
    e_rdy  = (q.size() <= 2);
  endtask

  // one clock edge with the current inputs, then compare every output
  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    check("pred_valid",  {31'b0, pred_valid_o}, {31'b0, e_pv});
    check("pred_taken",  {31'b0, pred_taken_o}, {31'b0, e_pt});
    check("pred_target", pred_target_o, e_ptgt);
    check("upd_ready",   {31'b0, upd_ready_o},  {31'b0, e_rdy});
    check("upd_drop",    {31'b0, upd_drop_o},   {31'b0, e_drop});
    check("init_busy",   {31'b0, init_busy_o},  {31'b0, e_busy});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic lookup(input logic [31:0] pc);
    lu_valid_i = 1'b1; lu_pc_i = pc;
    tick();
    lu_valid_i = 1'b0;
  endtask

  task automatic send(input logic [1:0] v,
                      input logic [31:0] pc0, input logic [31:0] t0, input bit tk0, input bit j0,
                      input logic [31:0] pc1, input logic [31:0] t1, input bit tk1, input bit j1);
    upd_valid_i = v;
    upd_pc0_i = pc0; upd_target0_i = t0;
    upd_pc1_i = pc1; upd_target1_i = t1;
    upd_taken_i = {tk1, tk0}; upd_is_jal_i = {j1, j0};
    tick();
    upd_valid_i = 2'b00;
  endtask

  // reset pulse, then count cycles with init_busy_o high (bounded at 20)
  task automatic reset_and_count(output int n);
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (init_busy_o) n++;
      tick();
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] hi = $urandom;
    return (hi & 32'hFFFF_E000) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 15)) << 1);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    // 1: sweep length and lookup during INIT
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (init_busy_o) n++;
      if (k == 3) begin lu_valid_i = 1'b1; lu_pc_i = 32'h100; end
      tick();
      if (k == 3) begin
        check("t1_init_lu_valid", {31'b0, pred_valid_o}, 32'd1);
        check("t1_init_lu_taken", {31'b0, pred_taken_o}, 32'd0);
        lu_valid_i = 1'b0;
      end
    end
    check("t1_init_cycles", n, 32'd16);

    // 2: allocate and hit; same idx other tag misses
    send(2'b01, 32'h100, 32'h200, 1, 0, 32'h0, 32'h0, 0, 0);
    idle(2);
    lookup(32'h100);
    check("t2_hit_taken",  {31'b0, pred_taken_o}, 32'd1);
    check("t2_hit_target", pred_target_o, 32'h200);
    lookup(32'h120);
    check("t2_alias_taken", {31'b0, pred_taken_o}, 32'd0);

    // 3: counter walk T,T,NT,NT -> predictions T,T,T,NT
    send(2'b01, 32'h80, 32'h300, 1, 0, 32'h0, 32'h0, 0, 0); idle(2); lookup(32'h80);
    check("t3_ctr2", {31'b0, pred_taken_o}, 32'd1);
    send(2'b01, 32'h80, 32'h300, 1, 0, 32'h0, 32'h0, 0, 0); idle(2); lookup(32'h80);
    check("t3_ctr3", {31'b0, pred_taken_o}, 32'd1);
    send(2'b01, 32'h80, 32'h300, 0, 0, 32'h0, 32'h0, 0, 0); idle(2); lookup(32'h80);
    check("t3_ctr2b", {31'b0, pred_taken_o}, 32'd1);
    send(2'b01, 32'h80, 32'h300, 0, 0, 32'h0, 32'h0, 0, 0); idle(2); lookup(32'h80);
    check("t3_ctr1", {31'b0, pred_taken_o}, 32'd0);

    // 5: same-index pair applies ir0 then ir1
    send(2'b11, 32'h40, 32'h90, 1, 0, 32'h40, 32'h0, 0, 0);
    idle(3);
    lookup(32'h40);
    check("t5_same_idx_taken", {31'b0, pred_taken_o}, 32'd0);

    // 4: three pairs during INIT -> third dropped, queued four apply in order
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    send(2'b11, 32'h44, 32'h1000, 1, 0, 32'h46, 32'h2000, 1, 1);
    check("t4_ready_after1", {31'b0, upd_ready_o}, 32'd1);
    send(2'b11, 32'h44, 32'h1100, 1, 0, 32'h46, 32'h0, 0, 0);
    check("t4_ready_after2", {31'b0, upd_ready_o}, 32'd0);
    send(2'b11, 32'h48, 32'h3000, 1, 0, 32'h4A, 32'h3000, 1, 0);
    check("t4_drop_pulse", {31'b0, upd_drop_o}, 32'd1);
    tick();
    check("t4_drop_clear", {31'b0, upd_drop_o}, 32'd0);
    idle(24);
    lookup(32'h44);
    check("t4_ir0_target", pred_target_o, 32'h1100);
    lookup(32'h46);
    check("t4_ir1_taken",  {31'b0, pred_taken_o}, 32'd1);
    check("t4_ir1_target", pred_target_o, 32'h2000);
    lookup(32'h48);
    check("t4_dropped_taken", {31'b0, pred_taken_o}, 32'd0);

    // 6: reset with three entries queued
    send(2'b01, 32'h4A, 32'h5000, 1, 0, 32'h0, 32'h0, 0, 0);
    idle(2);
    lookup(32'h4A);
    check("t6_trained", {31'b0, pred_taken_o}, 32'd1);
    send(2'b11, 32'h4C, 32'h6000, 1, 0, 32'h4E, 32'h6000, 1, 0);
    send(2'b11, 32'h50, 32'h7000, 1, 0, 32'h52, 32'h7000, 1, 0);
    reset_and_count(n);
    check("t6_resweep_cycles", n, 32'd16);
    check("t6_ready", {31'b0, upd_ready_o}, 32'd1);
    idle(4);
    lookup(32'h4A);
    check("t6_old_miss", {31'b0, pred_taken_o}, 32'd0);
    lookup(32'h50);
    check("t6_queued_gone", pred_target_o, 32'h0);

    // random traffic against the model
    for (int k = 0; k < 900; k++) begin
      rst_i       = ($urandom_range(0, 299) == 0);
      lu_valid_i  = $urandom_range(0, 1);
      lu_pc_i     = rnd_pc();
      upd_valid_i = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      upd_pc0_i   = rnd_pc();
      upd_pc1_i   = ($urandom_range(0, 3) == 0) ? upd_pc0_i : rnd_pc();
      upd_target0_i = $urandom;
      upd_target1_i = $urandom;
      upd_taken_i   = 2'($urandom_range(0, 3));
      upd_is_jal_i  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      tick();
    end
    rst_i = 1'b0; upd_valid_i = 2'b00; lu_valid_i = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
